// File: rtl/pp_pkg.sv
// Shared types and constants for the pipelined processor's memory stage.
package pp_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_REQ,
    MS_WAIT
  } mem_state_e;

  localparam logic [31:0] DATA_SEG_BASE = 32'h1000_0000;

  // Byte-lane footprint of an access before shifting to its offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001;
      SZ_HALF: lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/pp_mem_align.sv
// Byte-lane steering for the memory stage: store enables/replication,
// load lane extraction with sign/zero extension, and misalignment detect.
module pp_mem_align
  import pp_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        zero_ext,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b  = load_word[{offset, 3'b000} +: 8];
  assign lane_h  = offset[1] ? load_word[31:16] : load_word[15:0];
  assign byte_en = lane_mask(size) << offset;

  always_comb begin
    store_word = store_data;
    load_data  = load_word;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        store_word = {4{store_data[7:0]}};
        load_data  = zero_ext ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        misaligned = offset[0];
        store_word = {2{store_data[15:0]}};
        load_data  = zero_ext ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      default: begin
        misaligned = |offset;
      end
    endcase
  end

endmodule

// File: rtl/pp_mem_stage.sv
// Pipeline stage 4: load/store over a single-outstanding req/gnt/rvalid
// handshake, stalling upstream until the access completes, into MEM/WB.
module pp_mem_stage
  import pp_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [ADDR_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  output logic              stall_o,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_exc_misaligned
);

  mem_state_e state, state_nxt;

  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [1:0]        req_size;
  logic              req_uns;
  logic              req_we;
  logic [REG_AW-1:0] req_rd;
  logic              req_regw;

  logic              idle;
  logic              mem_op;
  logic              issue;
  logic              resp;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic [1:0]        cur_size;
  logic              cur_uns;
  logic              cur_we;
  logic [3:0]        lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] load_data;
  logic              misaligned;

  assign idle   = (state == MS_IDLE);
  assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);
  assign issue  = idle & mem_op & ~misaligned;
  assign resp   = (state == MS_WAIT) & dmem_rvalid;

  // Once issued, the request is driven from a private copy so REQ/WAIT
  // stay correct even if EX/MEM is not perfectly held.
  assign cur_addr = idle ? ex_alu_result : req_addr;
  assign cur_data = idle ? ex_store_data : req_data;
  assign cur_size = idle ? ex_size       : req_size;
  assign cur_uns  = idle ? ex_unsigned   : req_uns;
  assign cur_we   = idle ? ex_mem_write  : req_we;

  pp_mem_align u_align (
    .size       (cur_size),
    .offset     (cur_addr[1:0]),
    .zero_ext   (cur_uns),
    .store_data (cur_data),
    .load_word  (dmem_rdata),
    .byte_en    (lane_be),
    .store_word (lane_wdata),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  always_comb begin
    state_nxt = state;
    dmem_req  = 1'b0;
    stall_o   = 1'b0;
    case (state)
      MS_IDLE: begin
        if (issue) begin
          dmem_req  = 1'b1;
          stall_o   = 1'b1;
          state_nxt = dmem_gnt ? MS_WAIT : MS_REQ;
        end
      end
      MS_REQ: begin
        dmem_req = 1'b1;
        stall_o  = 1'b1;
        if (dmem_gnt) state_nxt = MS_WAIT;
      end
      MS_WAIT: begin
        stall_o = ~dmem_rvalid;
        if (dmem_rvalid) state_nxt = MS_IDLE;
      end
      default: state_nxt = MS_IDLE;
    endcase
    // Reset is asynchronous, so combinational outputs are quieted too.
    if (!rstb) begin
      dmem_req = 1'b0;
      stall_o  = 1'b0;
    end
  end

  assign dmem_we    = dmem_req & cur_we;
  assign dmem_addr  = {cur_addr[ADDR_W-1:2], 2'b00};
  assign dmem_be    = dmem_req ? lane_be : '0;
  assign dmem_wdata = lane_wdata;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= MS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      req_addr <= '0;
      req_data <= '0;
      req_size <= '0;
      req_uns  <= 1'b0;
      req_we   <= 1'b0;
      req_rd   <= '0;
      req_regw <= 1'b0;
    end else if (issue) begin
      req_addr <= ex_alu_result;
      req_data <= ex_store_data;
      req_size <= ex_size;
      req_uns  <= ex_unsigned;
      req_we   <= ex_mem_write;
      req_rd   <= ex_rd;
      req_regw <= ex_reg_write;
    end
  end

  // MEM/WB: pass-through when idle and not issuing, result on response,
  // bubble otherwise (rd/data hold their last value).
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wb_valid          <= 1'b0;
      wb_rd             <= '0;
      wb_reg_write      <= 1'b0;
      wb_data           <= '0;
      wb_exc_misaligned <= 1'b0;
    end else if (idle && !issue) begin
      wb_valid          <= ex_valid;
      wb_rd             <= ex_rd;
      wb_reg_write      <= ex_valid & ex_reg_write & ~mem_op & (ex_rd != '0);
      wb_data           <= DATA_W'(ex_alu_result);
      wb_exc_misaligned <= mem_op & misaligned;
    end else if (resp) begin
      wb_valid          <= 1'b1;
      wb_rd             <= req_rd;
      wb_reg_write      <= req_regw & ~req_we & (req_rd != '0);
      wb_data           <= req_we ? DATA_W'(req_addr) : load_data;
      wb_exc_misaligned <= 1'b0;
    end else begin
      wb_valid          <= 1'b0;
      wb_reg_write      <= 1'b0;
      wb_exc_misaligned <= 1'b0;
    end
  end

endmodule
